// File: rtl/auto_drive_sequencer.sv
// Semi-auto drive sequencer: cruises along corridors, turns at dead ends and single openings,
// and waits for a user decision at forks. Motion commands are registered and one-hot.
module auto_drive_sequencer #(
    parameter int TURN_MS = 900,
    parameter int EXIT_MS = 400
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ms_tick,
    input  logic       front_detector,
    input  logic       left_detector,
    input  logic       right_detector,
    input  logic       go_cmd,
    input  logic       left_cmd,
    input  logic       right_cmd,
    output logic       move_forward,
    output logic       turn_left,
    output logic       turn_right,
    output logic       fork_wait,
    output logic [2:0] state_code
);

    // state  | meaning
    // IDLE   | disabled, all outputs low
    // CRUISE | driving forward along a corridor
    // WAIT   | fork found, waiting for a user decision
    // TURN   | timed turn toward the latched direction
    // EXIT   | timed forward move clearing the junction, detectors ignored
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CRUISE = 3'd1,
        WAIT   = 3'd2,
        TURN   = 3'd3,
        EXIT   = 3'd4
    } state_t;

    localparam logic [15:0] TURN_LD  = 16'(TURN_MS);
    localparam logic [15:0] TURN2_LD = 16'(2 * TURN_MS);
    localparam logic [15:0] EXIT_LD  = 16'(EXIT_MS);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        dir_right, dir_nx;
    logic [1:0]  open_cnt;

    assign open_cnt = {1'b0, ~front_detector} + {1'b0, ~left_detector} + {1'b0, ~right_detector};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dir_nx   = dir_right;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = 16'd0;
        end else begin
            case (state)
                IDLE: state_nx = CRUISE;
                CRUISE: begin
                    if (open_cnt >= 2'd2) begin
                        state_nx = WAIT;
                    end else if (open_cnt == 2'd1) begin
                        // a single open side means a forced turn; front-only keeps cruising
                        if (!left_detector) begin
                            state_nx = TURN;
                            cnt_nx   = TURN_LD;
                            dir_nx   = 1'b0;
                        end else if (!right_detector) begin
                            state_nx = TURN;
                            cnt_nx   = TURN_LD;
                            dir_nx   = 1'b1;
                        end
                    end else begin
                        state_nx = TURN;
                        cnt_nx   = TURN2_LD;
                        dir_nx   = 1'b1;
                    end
                end
                WAIT: begin
                    if (go_cmd && !front_detector) begin
                        state_nx = EXIT;
                        cnt_nx   = EXIT_LD;
                    end else if (left_cmd && !left_detector) begin
                        state_nx = TURN;
                        cnt_nx   = TURN_LD;
                        dir_nx   = 1'b0;
                    end else if (right_cmd && !right_detector) begin
                        state_nx = TURN;
                        cnt_nx   = TURN_LD;
                        dir_nx   = 1'b1;
                    end
                end
                TURN, EXIT: begin
                    if (ms_tick) begin
                        if (cnt <= 16'd1) begin
                            state_nx = (state == TURN) ? EXIT : CRUISE;
                            cnt_nx   = (state == TURN) ? EXIT_LD : 16'd0;
                        end else begin
                            cnt_nx = cnt - 16'd1;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 16'd0;
            dir_right    <= 1'b0;
            move_forward <= 1'b0;
            turn_left    <= 1'b0;
            turn_right   <= 1'b0;
            fork_wait    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            dir_right    <= dir_nx;
            // outputs decoded from the next state so they are valid in the first cycle of each state
            move_forward <= (state_nx == CRUISE) || (state_nx == EXIT);
            turn_left    <= (state_nx == TURN) && !dir_nx;
            turn_right   <= (state_nx == TURN) && dir_nx;
            fork_wait    <= (state_nx == WAIT);
        end
    end

    assign state_code = state;

endmodule

// File: doc/auto_drive_sequencer.md
AUTO_DRIVE_SEQUENCER -- requirements
Module: auto_drive_sequencer

Interface
REQ-001 Parameter TURN_MS, default 900, SHALL set the single-turn duration in ms ticks (legal range 1..32767).
REQ-002 Parameter EXIT_MS, default 400, SHALL set the forward fork-clearing duration in ms ticks (legal range 1..65535).
REQ-003 Port sys_clk  in  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port enable  in  1  SHALL be high while semi-auto driving mode is selected.
REQ-006 Port ms_tick  in  1  SHALL be a one-sys_clk-wide pulse, once per ms.
REQ-007 Ports front_detector, left_detector, right_detector  in  1 each  SHALL be 1 = blocked, 0 = open.
REQ-008 Ports go_cmd, left_cmd, right_cmd  in  1 each  SHALL be single-cycle user decision pulses.
REQ-009 Ports move_forward, turn_left, turn_right  out  1 each  SHALL be the motion commands to the UART command byte.
REQ-010 Port fork_wait  out  1  SHALL be high while waiting for a user decision.
REQ-011 Port state_code  out  3  SHALL expose the current state encoding.

Function
REQ-012 States SHALL be IDLE=0, CRUISE=1, WAIT=2, TURN=3, EXIT=4; codes 5..7 SHALL recover to IDLE on the next edge.
REQ-013 Outputs SHALL be decoded from registered state only (Moore) and are valid in the first cycle of each state.
REQ-014 enable=0 SHALL force IDLE on the next edge from any state; this overrides all other transitions.
REQ-015 IDLE: all motion outputs 0; enable=1 SHALL move to CRUISE.
REQ-016 CRUISE: with open = count of detectors at 0 among front/left/right, the following SHALL apply:
  - open>=2: go to WAIT.
  - only front open: stay; move_forward=1.
  - only left or only right open: go to TURN toward that side; load TURN_MS.
  - open=0: go to TURN right; load 2*TURN_MS.
REQ-017 WAIT: all motion outputs 0 and fork_wait=1.
REQ-018 WAIT SHALL accept a command only if its direction is open; a pulse toward a blocked side SHALL be ignored.
REQ-019 WAIT command priority SHALL be go_cmd > left_cmd > right_cmd when pulses coincide.
  - go_cmd: go to EXIT; load EXIT_MS.
  - left_cmd / right_cmd: go to TURN toward that side; load TURN_MS.
REQ-020 TURN: exactly one of turn_left/turn_right=1 per the latched direction register; move_forward=0.
REQ-021 TURN: the 16-bit down-counter SHALL decrement on each ms_tick.
REQ-022 TURN SHALL leave on the edge of the Nth ms_tick after entry (N = loaded value) and go to EXIT with EXIT_MS loaded.
REQ-023 EXIT: move_forward=1; detectors SHALL be ignored.
REQ-024 EXIT: the counter SHALL count as in TURN; after EXIT_MS ticks the block SHALL go to CRUISE.
REQ-025 An ms_tick in the same cycle as state entry SHALL NOT be counted.
REQ-026 The counter SHALL never wrap below 0.
REQ-027 The direction register SHALL only change on entry to TURN.
REQ-028 At most one of move_forward, turn_left, turn_right SHALL be 1 in any cycle.

Reset
REQ-029 While rst=0, the block SHALL hold state IDLE, counter 0, direction left, and all outputs 0 (state_code=0, fork_wait=0).
REQ-030 Reset asserted mid-TURN or mid-EXIT SHALL abort at once; after release the block SHALL wait in IDLE until it sees enable=1.

Verification (TURN_MS=5, EXIT_MS=3, ms_tick every 10 cycles)
REQ-031 Scenario: rst released, enable=1, detectors F/L/R=0/1/1 -> CRUISE, move_forward=1 held for 100 cycles.
REQ-032 Scenario: in CRUISE, F/L/R=1/0/1 -> TURN left.
  - turn_left=1 for exactly 5 ticks.
  - Then EXIT with move_forward=1 for 3 ticks.
  - Then CRUISE.
REQ-033 Scenario: F/L/R=0/0/1 -> WAIT, fork_wait=1, outputs 0.
  - right_cmd pulse -> ignored.
  - left_cmd and go_cmd pulsed in the same cycle -> EXIT, 3 ticks.
REQ-034 Scenario: F/L/R=1/1/1 -> TURN right held 10 ticks, then EXIT.
REQ-035 Scenario: enable dropped at tick 2 of TURN -> IDLE next edge, outputs 0.
  - enable re-raised with F/L/R=0/1/1 -> CRUISE, move_forward=1.
REQ-036 Scenario: rst pulsed low mid-EXIT -> outputs 0 asynchronously, state_code=0, IDLE held until enable=1.
